// File: rtl/keypad_emulator.sv
// keypad_emulator -- responder end of a 4x4 matrix-keypad scan interface.
//
// Key codes are queued in a small FIFO by a test source. Each key is popped,
// held pressed for HOLD_SCANS full column scans, then released for GAP_SCANS
// scans before the next key. While a key is pressed, its row line follows its
// column strobe combinationally, as a physical switch closure would.
//
// Optional feature: define KPEMU_BOUNCE_EN to emulate contact bounce during
// the first two scans of each press, using an 8-bit LFSR.
//
// Ports:
//   clk         single clock (scanner clock domain)
//   reset       synchronous, active-high
//   key_in      key code: row = key_in[3:2], column = key_in[1:0]
//   key_valid   push request; accepted when key_valid && key_ready
//   key_ready   FIFO not full
//   kb_col      column strobes from the scanner (active-high)
//   kb_row      row returns to the scanner (active-high)
//   busy        key in progress or keys queued
//   key_done    one-cycle pulse when a key finishes its gap
//   fifo_count  number of queued keys
module keypad_emulator #(
  parameter int DEPTH      = 8,
  parameter int HOLD_SCANS = 4,
  parameter int GAP_SCANS  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               key_in,
  input  logic                     key_valid,
  output logic                     key_ready,
  input  logic [3:0]               kb_col,
  output logic [3:0]               kb_row,
  output logic                     busy,
  output logic                     key_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXS = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
  localparam int CW   = $clog2(MAXS + 1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  state_t        state_q;
  logic [3:0]    cur_key_q;
  logic [CW-1:0] scan_cnt_q;
  logic          col3_q;
  logic          key_done_q;

  logic          push, pop, scan_ev;
  logic [CW-1:0] scan_nxt;

  assign key_ready  = (cnt_q != (AW+1)'(DEPTH));
  assign push       = key_valid && key_ready;
  // IDLE pops whenever anything is queued; no other state consumes the FIFO.
  assign pop        = (state_q == IDLE) && (cnt_q != '0);
  // A rising edge on the last column strobe marks one completed scan.
  assign scan_ev    = kb_col[3] && !col3_q;
  assign scan_nxt   = scan_cnt_q + CW'(1);
  assign busy       = (state_q != IDLE) || (cnt_q != '0);
  assign key_done   = key_done_q;
  assign fifo_count = cnt_q;

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= key_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_key_q  <= '0;
      scan_cnt_q <= '0;
      col3_q     <= 1'b0;
      key_done_q <= 1'b0;
    end else begin
      col3_q     <= kb_col[3];
      key_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            cur_key_q  <= mem_q[rptr_q];
            scan_cnt_q <= '0;
            state_q    <= PRESS;
          end
        end
        PRESS: begin
          if (scan_ev) begin
            if (scan_nxt == CW'(HOLD_SCANS)) begin
              scan_cnt_q <= '0;
              state_q    <= GAP;
            end else begin
              scan_cnt_q <= scan_nxt;
            end
          end
        end
        GAP: begin
          if (scan_ev) begin
            if (scan_nxt == CW'(GAP_SCANS)) begin
              scan_cnt_q <= '0;
              key_done_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              scan_cnt_q <= scan_nxt;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic contact;

`ifdef KPEMU_BOUNCE_EN
  // Fibonacci LFSR, taps 8,6,5,4; steps once per scan regardless of state.
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk) begin
    if (reset)        lfsr_q <= 8'h01;
    else if (scan_ev) lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end

  // Contact chatters only over the first two scans of a press.
  assign contact = (scan_cnt_q < CW'(2)) ? lfsr_q[0] : 1'b1;
`else
  assign contact = 1'b1;
`endif

  always_comb begin
    kb_row = '0;
    if (state_q == PRESS)
      kb_row[cur_key_q[3:2]] = kb_col[cur_key_q[1:0]] && contact;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] kb_col;
  logic [3:0] kb_row;
  logic       busy;
  logic       key_done;
  logic [3:0] fifo_count;

  int n_cmp  = 0;
  int n_fail = 0;

  keypad_emulator #(.DEPTH(8), .HOLD_SCANS(4), .GAP_SCANS(4)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .kb_col(kb_col), .kb_row(kb_row), .busy(busy),
    .key_done(key_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; key_valid = 1'b0; key_in = 4'h0; kb_col = 4'h0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [3:0] k);
    key_in = k; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  function automatic logic [1:0] enc(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

  // Runs a 4-phase one-hot scanner (8 clocks per column) from column 0 until
  // key_done is seen, then steps past the following edge.
  task automatic observe_key(output logic [3:0] code, output int rowcyc,
                             output int done_tc);
    bit got;
    got = 0; code = 4'h0; rowcyc = 0; done_tc = -1;
    for (int t = 0; t < 400; t++) begin
      kb_col = 4'b0001 << ((t / 8) % 4);
      #1;
      if (kb_row != 4'h0) begin
        rowcyc++;
        if (!got) begin got = 1; code = {enc(kb_row), enc(kb_col)}; end
      end
      if (key_done) begin done_tc = t; tick(); break; end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    kb_col = 4'b1111; #1;
    n_cmp++; if (kb_row !== 4'h0) begin n_fail++; $display("FAIL reset_kb_row got %b want 0000", kb_row); end
    n_cmp++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready got %b want 1", key_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (key_done !== 1'b0) begin n_fail++; $display("FAIL reset_key_done got %b want 0", key_done); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
    kb_col = 4'h0;
  endtask

  task automatic test_single_key();
    logic [3:0] code; int rc, dt;
    do_reset();
    push(4'b0110);
    n_cmp++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL push_count got %0d want 1", fifo_count); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL push_busy got %b want 1", busy); end
    tick();
    n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL pop_count got %0d want 0", fifo_count); end
    kb_col = 4'b0100; #1;
    n_cmp++; if (kb_row !== 4'b0010) begin n_fail++; $display("FAIL press_row got %b want 0010", kb_row); end
    kb_col = 4'b0010; #1;
    n_cmp++; if (kb_row !== 4'b0000) begin n_fail++; $display("FAIL press_other_col got %b want 0000", kb_row); end
    observe_key(code, rc, dt);
    n_cmp++; if (code !== 4'b0110) begin n_fail++; $display("FAIL single_code got %b want 0110", code); end
`ifndef KPEMU_BOUNCE_EN
    n_cmp++; if (rc !== 32) begin n_fail++; $display("FAIL single_row_cycles got %0d want 32", rc); end
`endif
    n_cmp++; if (dt !== 249) begin n_fail++; $display("FAIL single_done_time got %0d want 249", dt); end
    n_cmp++; if (key_done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", key_done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_fifo_full_replay();
    logic [3:0] code; int rc, dt;
    do_reset();
    for (int k = 0; k < 8; k++) push(4'(k));
    n_cmp++; if (fifo_count !== 4'd7) begin n_fail++; $display("FAIL fill_count7 got %0d want 7", fifo_count); end
    n_cmp++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready7 got %b want 1", key_ready); end
    push(4'd8);
    n_cmp++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL fill_count8 got %0d want 8", fifo_count); end
    n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", key_ready); end
    push(4'd9);
    n_cmp++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_push_ignored got %0d want 8", fifo_count); end
    for (int k = 0; k < 9; k++) begin
      observe_key(code, rc, dt);
      n_cmp++; if (code !== 4'(k)) begin n_fail++; $display("FAIL replay_code[%0d] got %0d want %0d", k, code, k); end
      n_cmp++; if (dt !== 249) begin n_fail++; $display("FAIL replay_done[%0d] got %0d want 249", k, dt); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL replay_busy got %b want 0", busy); end
  endtask

  task automatic test_full_pop_push();
    bit seen;
    do_reset();
    for (int k = 0; k < 9; k++) push(4'(k));
    n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL fp_ready got %b want 0", key_ready); end
    key_in = 4'hF; key_valid = 1'b1; seen = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      kb_col = 4'b0001 << ((t / 8) % 4);
      #1;
      if (key_done) seen = 1;
      tick();
    end
    // The edge just taken is the pop edge, with the FIFO still full at it.
    key_valid = 1'b0;
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL fp_timeout got no key_done want key_done"); end
    n_cmp++; if (fifo_count !== 4'd7) begin n_fail++; $display("FAIL fp_count got %0d want 7", fifo_count); end
    n_cmp++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL fp_ready_after got %b want 1", key_ready); end
  endtask

  task automatic test_reset_mid_press();
    int bad;
    do_reset();
    push(4'hF);
    push(4'h5);
    kb_col = 4'b1000; #1;
    n_cmp++; if (kb_row !== 4'b1000) begin n_fail++; $display("FAIL rmp_press_row got %b want 1000", kb_row); end
    reset = 1'b1;
    tick();
    n_cmp++; if (kb_row !== 4'h0) begin n_fail++; $display("FAIL rmp_row got %b want 0000", kb_row); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rmp_count got %0d want 0", fifo_count); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmp_busy got %b want 0", busy); end
    reset = 1'b0;
    bad = 0;
    for (int t = 0; t < 80; t++) begin
      kb_col = 4'b0001 << ((t / 8) % 4);
      #1;
      if (key_done !== 1'b0 || kb_row !== 4'h0 || busy !== 1'b0) bad++;
      tick();
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rmp_quiet got %0d active cycles want 0", bad); end
    kb_col = 4'h0;
  endtask

  task automatic test_multi_col();
    do_reset();
    push(4'b0001);
    tick();
    kb_col = 4'b1010; #1;
    n_cmp++; if (kb_row !== 4'b0001) begin n_fail++; $display("FAIL multi_1010 got %b want 0001", kb_row); end
    kb_col = 4'b0101; #1;
    n_cmp++; if (kb_row !== 4'b0000) begin n_fail++; $display("FAIL multi_0101 got %b want 0000", kb_row); end
    kb_col = 4'h0;
  endtask

`ifdef KPEMU_BOUNCE_EN
  task automatic test_bounce();
    logic [7:0] ref_l;
    logic       exp;
    do_reset();
    push(4'b0000);
    tick();
    ref_l = 8'h01;
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 32; t++) begin
        kb_col = 4'b0001 << (t / 8);
        #1;
        if (t < 8) begin
          exp = (k >= 4) ? 1'b0 : (k < 2) ? ref_l[0] : 1'b1;
          n_cmp++; if (kb_row[0] !== exp) begin n_fail++; $display("FAIL bounce[%0d] got %b want %b", k, kb_row[0], exp); end
        end
        if (t == 24) ref_l = {ref_l[6:0], ref_l[7] ^ ref_l[5] ^ ref_l[4] ^ ref_l[3]};
        tick();
      end
    end
    kb_col = 4'h0;
  endtask
`endif

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_in = 4'h0; kb_col = 4'h0;
    test_reset();
    test_single_key();
    test_fifo_full_replay();
    test_full_pop_push();
    test_reset_mid_press();
    test_multi_col();
`ifdef KPEMU_BOUNCE_EN
    test_bounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
